// File: rtl/bcd_calc_engine.sv
// Button-driven BCD calculator datapath: digit entry and recall, then a
// sequential load / execute / double-dabble pipeline for add, sub, mul and rounded divide.
module bcd_calc_engine #(
    parameter int DIGITS  = 2,
    parameter int LOCKOUT = 10
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset_n,
    input  logic [2*DIGITS-1:0]   digit_btn,
    input  logic [3:0]            op_btn,
    input  logic                  recall_btn,
    output logic [8*DIGITS-1:0]   display_bcd,
    output logic                  negative,
    output logic                  entry_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  div_error
);
    localparam int AW = $clog2(10**DIGITS);
    localparam int RW = $clog2(10**(2*DIGITS));
    localparam int ND = 2*DIGITS;
    localparam int DW = 4*ND;
    localparam int NW = AW + 4;
    localparam int LW = $clog2(LOCKOUT + 2);
    localparam int CW = $clog2(RW + NW + 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_CONV, S_WRITE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          btn_q;
    logic [DW-1:0] disp_q, disp_d, saved_q, saved_d, bcd_q, bcd_d;
    logic          neg_q, neg_d, entry_q, entry_d, derr_q, derr_d, sign_q, sign_d;
    logic [AW-1:0] a_q, a_d, b_q, b_d;
    logic [NW-1:0] num_q, num_d, num_sh, quot10, rmd10;
    logic [AW:0]   rem_q, rem_d, rem_sh;
    logic [RW-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [DW-1:0] bcd_adj;
    logic          btn_or, accept, found;
    int            ld_idx;

    // Double-dabble pre-shift correction: any digit >= 5 gets +3.
    for (genvar gi = 0; gi < ND; gi++) begin : g_dabble
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                                : bcd_q[4*gi +: 4];
    end

    assign btn_or = (|digit_btn) | (|op_btn) | recall_btn;
    assign accept = btn_or && !btn_q && (lock_q == '0) && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;  op_d = op_q;      cnt_d = cnt_q;      lock_d = lock_q;
        disp_d  = disp_q;   saved_d = saved_q; bcd_d = bcd_q;
        neg_d   = neg_q;    entry_d = entry_q; derr_d = derr_q;   sign_d = sign_q;
        a_d     = a_q;      b_d = b_q;         num_d = num_q;     rem_d = rem_q;
        acc_d   = acc_q;    mcand_d = mcand_q;
        num_sh  = '0;       rem_sh = '0;       quot10 = '0;       rmd10 = '0;
        found   = 1'b0;
        ld_idx  = (cnt_q == '0) ? 1 : int'(cnt_q);

        if (lock_q != '0) lock_d = lock_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lock_d = LW'(LOCKOUT);
                    if (recall_btn) begin
                        disp_d = saved_q; entry_d = 1'b1; neg_d = 1'b0; derr_d = 1'b0;
                    end else if (|op_btn) begin
                        op_d    = op_btn[3] ? OP_ADD : op_btn[2] ? OP_SUB : op_btn[1] ? OP_MUL : OP_DIV;
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else begin
                        for (int i = 0; i < ND; i++) begin
                            if (digit_btn[i] && !found) begin
                                found = 1'b1;
                                disp_d[4*i +: 4] = (disp_q[4*i +: 4] == 4'd9) ? 4'd0 : disp_q[4*i +: 4] + 4'd1;
                            end
                        end
                        saved_d = disp_d; entry_d = 1'b1; neg_d = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                // Cycle 0 clears the accumulators, then one digit of each operand per cycle, MS first.
                if (cnt_q == '0) begin
                    a_d = '0; b_d = '0;
                end else begin
                    a_d = a_q * AW'(10) + AW'(disp_q[4*(ND-ld_idx) +: 4]);
                    b_d = b_q * AW'(10) + AW'(disp_q[4*(DIGITS-ld_idx) +: 4]);
                end
                if (cnt_q == CW'(DIGITS)) begin
                    num_d   = NW'(a_d) * NW'(10);
                    mcand_d = RW'(b_d);
                    rem_d   = '0; acc_d = '0; sign_d = 1'b0;
                    state_d = S_EXEC; cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: if (cnt_q == '0) acc_d = RW'(a_q) + RW'(b_q);
                    OP_SUB: if (cnt_q == '0) begin
                        if (b_q > a_q) begin
                            acc_d = RW'(b_q - a_q); sign_d = 1'b1;
                        end else begin
                            acc_d = RW'(a_q - b_q); sign_d = 1'b0;
                        end
                    end
                    OP_MUL: begin
                        // Multiplier drains to zero after AW shifts, so later cycles add nothing.
                        if (a_q[0]) acc_d = acc_q + mcand_q;
                        a_d     = a_q >> 1;
                        mcand_d = mcand_q << 1;
                    end
                    default: begin
                        rem_sh = {rem_q[AW-1:0], num_q[NW-1]};
                        num_sh = {num_q[NW-2:0], 1'b0};
                        if (rem_sh >= {1'b0, b_q}) begin
                            rem_sh    = rem_sh - {1'b0, b_q};
                            num_sh[0] = 1'b1;
                        end
                        rem_d = rem_sh;
                        num_d = num_sh;
                    end
                endcase
                if (cnt_q == CW'(NW-1)) begin
                    if (op_q == OP_DIV) begin
                        quot10 = num_d / NW'(10);
                        rmd10  = num_d % NW'(10);
                        if (b_q == '0) begin
                            acc_d = '0; derr_d = 1'b1;
                        end else begin
                            acc_d = RW'(quot10) + RW'(rmd10 >= NW'(5)); derr_d = 1'b0;
                        end
                    end
                    bcd_d = '0; state_d = S_CONV; cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[DW-2:0], acc_q[RW-1]};
                acc_d = acc_q << 1;
                if (cnt_q == CW'(RW-1)) begin
                    disp_d = bcd_d; neg_d = sign_q; entry_d = 1'b0;
                    state_d = S_WRITE; cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE; op_q <= OP_ADD; cnt_q <= '0; lock_q <= '0; btn_q <= 1'b0;
            disp_q  <= '0; saved_q <= '0; bcd_q <= '0;
            neg_q   <= 1'b0; entry_q <= 1'b1; derr_q <= 1'b0; sign_q <= 1'b0;
            a_q     <= '0; b_q <= '0; num_q <= '0; rem_q <= '0; acc_q <= '0; mcand_q <= '0;
        end else begin
            state_q <= state_d; op_q <= op_d; cnt_q <= cnt_d; lock_q <= lock_d; btn_q <= btn_or;
            disp_q  <= disp_d; saved_q <= saved_d; bcd_q <= bcd_d;
            neg_q   <= neg_d; entry_q <= entry_d; derr_q <= derr_d; sign_q <= sign_d;
            a_q     <= a_d; b_q <= b_d; num_q <= num_d; rem_q <= rem_d; acc_q <= acc_d; mcand_q <= mcand_d;
        end
    end

    assign display_bcd = disp_q;
    assign negative    = neg_q;
    assign entry_mode  = entry_q;
    assign div_error   = derr_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_WRITE);
endmodule

// File: tb/tb_bcd_calc_engine.sv
// Bench for bcd_calc_engine: fixed vectors, hand-written corner sequences and
// randomized ops checked against a decimal-arithmetic reference model.
module tb_bcd_calc_engine;
    localparam int ND       = 4;
    localparam int LK       = 10;
    localparam int BUSY_CYC = 29;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] digit_btn = '0;
    logic [3:0]    op_btn = '0;
    logic          recall_btn = 1'b0;
    logic [15:0]   display_bcd;
    logic          negative, entry_mode, busy, done, div_error;

    int checks = 0, errors = 0;
    int dval = 0, saved = 0, mneg = 0, merr = 0;

    typedef struct {
        int a; int b; int op; int res; int neg; int err;
    } vec_t;

    always #5 clk = ~clk;

    bcd_calc_engine #(.DIGITS(2), .LOCKOUT(LK)) dut (
        .clock_100Mhz(clk), .reset_n(rst_n), .digit_btn(digit_btn), .op_btn(op_btn),
        .recall_btn(recall_btn), .display_bcd(display_bcd), .negative(negative),
        .entry_mode(entry_mode), .busy(busy), .done(done), .div_error(div_error)
    );

    function automatic int pow10(input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return p;
    endfunction

    function automatic int to_bcd(input int v);
        int r = 0;
        for (int i = 0; i < ND; i++) r = r | (((v / pow10(i)) % 10) << (4*i));
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (hex)", name, act, exp);
        end
    endtask

    task automatic ref_calc(input int a, input int b, input int op,
                            output int r, output int neg, output int err);
        int q;
        neg = 0; err = merr; r = 0;
        case (op)
            0: r = a + b;
            1: begin r = (a > b) ? a - b : b - a; neg = (b > a) ? 1 : 0; end
            2: r = a * b;
            default: begin
                if (b == 0) begin r = 0; err = 1; end
                else begin q = (a * 10) / b; r = q / 10 + ((q % 10 >= 5) ? 1 : 0); err = 0; end
            end
        endcase
    endtask

    task automatic model_inc(input int i);
        int p, d;
        p = pow10(i);
        d = (dval / p) % 10;
        dval = dval + (((d + 1) % 10) - d) * p;
        saved = dval; mneg = 0;
    endtask

    task automatic press(input logic [ND-1:0] dmask, input logic rc);
        @(negedge clk); digit_btn = dmask; recall_btn = rc;
        @(negedge clk); digit_btn = '0; recall_btn = 1'b0;
        repeat (LK + 1) @(negedge clk);
    endtask

    task automatic press_digit(input int i);
        press(ND'(1 << i), 1'b0);
        model_inc(i);
    endtask

    task automatic press_recall();
        press('0, 1'b1);
        dval = saved; mneg = 0; merr = 0;
        $display("recall -> display %h entry %0d", display_bcd, entry_mode);
        chk("recall_display", int'(display_bcd), to_bcd(dval));
        chk("recall_entry", int'(entry_mode), 1);
        chk("recall_neg", int'(negative), 0);
    endtask

    task automatic set_operands(input int a, input int b);
        int t, p, need;
        t = a * 100 + b;
        for (int i = 0; i < ND; i++) begin
            p = pow10(i);
            need = (((t / p) % 10) - ((dval / p) % 10) + 10) % 10;
            repeat (need) press_digit(i);
        end
        chk("operand_display", int'(display_bcd), to_bcd(dval));
        chk("operand_entry", int'(entry_mode), 1);
    endtask

    task automatic do_op(input int opsel, input int expv, input int expneg, input int experr,
                         input logic [ND-1:0] extra, input bit intr);
        int busy_n = 0, done_n = 0, cap_disp = -1, cap_neg = -1, cap_entry = -1, cap_err = -1;
        int a, b;
        a = dval / 100; b = dval % 100;
        @(negedge clk); op_btn = 4'b1000 >> opsel; digit_btn = extra;
        @(negedge clk); op_btn = '0; digit_btn = '0;
        for (int k = 0; k < 100; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                cap_disp = int'(display_bcd); cap_neg = int'(negative);
                cap_entry = int'(entry_mode); cap_err = int'(div_error);
            end
            if (!busy) break;
            op_btn = (intr && k == 10) ? 4'b1000 : 4'b0000;
            @(negedge clk);
        end
        op_btn = '0;
        $display("op %0d A=%0d B=%0d -> display %h neg %0d err %0d busy_cycles %0d",
                 opsel, a, b, cap_disp, cap_neg, cap_err, busy_n);
        chk("busy_cycles", busy_n, BUSY_CYC);
        chk("done_pulses", done_n, 1);
        chk("result_display", cap_disp, to_bcd(expv));
        chk("result_neg", cap_neg, expneg);
        chk("result_entry", cap_entry, 0);
        chk("result_div_error", cap_err, experr);
        dval = expv; mneg = expneg; merr = experr;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_display"}, int'(display_bcd), 0);
        chk({tag, "_neg"}, int'(negative), 0);
        chk({tag, "_entry"}, int'(entry_mode), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_div_error"}, int'(div_error), 0);
    endtask

    vec_t vecs[11];

    initial begin
        int r, n, e, a, b, op, quiet_busy, done_seen;
        vecs[0]  = '{12, 30, 1,   18, 1, 0};
        vecs[1]  = '{30, 30, 1,    0, 0, 0};
        vecs[2]  = '{99, 99, 2, 9801, 0, 0};
        vecs[3]  = '{10,  3, 3,    3, 0, 0};
        vecs[4]  = '{ 5,  2, 3,    3, 0, 0};
        vecs[5]  = '{ 7,  0, 3,    0, 0, 1};
        vecs[6]  = '{99, 99, 0,  198, 0, 1};
        vecs[7]  = '{99,  1, 3,   99, 0, 0};
        vecs[8]  = '{ 1,  3, 3,    0, 0, 0};
        vecs[9]  = '{ 2,  3, 3,    1, 0, 0};
        vecs[10] = '{ 0,  7, 1,    7, 1, 0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Digit entry with per-digit wrap and no carry.
        repeat (3) press_digit(3);
        repeat (2) press_digit(1);
        $display("digits -> display %h", display_bcd);
        chk("entry_3020", int'(display_bcd), 16'h3020);
        chk("entry_mode_3020", int'(entry_mode), 1);
        repeat (7) press_digit(3);
        $display("digit3 wrap -> display %h", display_bcd);
        chk("wrap_0020", int'(display_bcd), 16'h0020);

        // Second edge 3 cycles after an accepted press falls inside the lockout.
        @(negedge clk); digit_btn = 4'b0001;
        @(negedge clk); digit_btn = '0;
        repeat (2) @(negedge clk);
        digit_btn = 4'b0010;
        @(negedge clk); digit_btn = '0;
        repeat (LK + 1) @(negedge clk);
        model_inc(0);
        $display("lockout -> display %h", display_bcd);
        chk("lockout_display", int'(display_bcd), 16'h0021);

        set_operands(45, 7);
        do_op(0, 52, 0, 0, '0, 1'b0);
        press_recall();
        chk("recall_4507", int'(display_bcd), 16'h4507);

        foreach (vecs[i]) begin
            set_operands(vecs[i].a, vecs[i].b);
            do_op(vecs[i].op, vecs[i].res, vecs[i].neg, vecs[i].err, '0, 1'b0);
        end

        // Add pressed mid-operation is dropped, and nothing restarts afterwards.
        set_operands(12, 34);
        do_op(0, 46, 0, 0, '0, 1'b1);
        quiet_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) quiet_busy++;
        end
        chk("no_restart_busy", quiet_busy, 0);
        chk("no_restart_display", int'(display_bcd), to_bcd(46));

        // Digit and add together: add wins.
        set_operands(20, 5);
        do_op(0, 25, 0, 0, 4'b0001, 1'b0);

        // Reset during the conversion phase of a divide-by-zero.
        set_operands(7, 0);
        done_seen = 0;
        @(negedge clk); op_btn = 4'b0001;
        @(negedge clk); op_btn = '0;
        for (int k = 0; k < 19; k++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        $display("abort -> display %h busy %0d done_seen %0d", display_bcd, busy, done_seen);
        chk("abort_no_done", done_seen, 0);
        check_reset_outputs("after_abort");
        dval = 0; saved = 0; mneg = 0; merr = 0;
        do_op(0, 0, 0, 0, '0, 1'b0);
        set_operands(3, 8);
        do_op(0, 11, 0, 0, '0, 1'b0);

        // Randomized operands and ops, sometimes chained on the previous result.
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) != 0) begin
                a = int'($urandom_range(0, 99));
                b = int'($urandom_range(0, 99));
                set_operands(a, b);
            end
            a = dval / 100; b = dval % 100;
            op = int'($urandom_range(0, 3));
            ref_calc(a, b, op, r, n, e);
            do_op(op, r, n, e, '0, 1'b0);
            if ($urandom_range(0, 4) == 0) press_recall();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_calc_engine.md
Name: bcd_calc_engine

Overview:
- Parametrised successor to the Basys 3 four-digit calculator datapath, with a generalised operand width of DIGITS decimal digits per operand.
- Accepts debounced-level push-button inputs and edits two packed BCD operands digit by digit.
- Runs add, subtract, multiply or rounded divide through a multi-cycle sequential datapath: BCD->binary, iterative execute, double-dabble binary->BCD.
- Presents the BCD result, sign, entry-mode and error flags to the existing seven-segment scan logic.

Parameters:
- DIGITS, 2, decimal digits per operand; the display holds 2*DIGITS digits.
- LOCKOUT, 10, cycles after an accepted press during which all further button edges are ignored.
- Derived (localparam, not overridable):
  - AW = bits to hold 10^DIGITS-1 (7 for DIGITS=2).
  - RW = bits to hold 10^(2*DIGITS)-1 (14 for DIGITS=2).

Ports:
- clock_100Mhz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- digit_btn  in  2*DIGITS  level inputs; bit i increments display digit i (bit 0 = least significant).
- op_btn  in  4  level inputs; [3]=add, [2]=sub, [1]=mul, [0]=div.
- recall_btn  in  1  level input; restores the last entered operands.
- display_bcd  out  8*DIGITS  packed BCD, digit i at [4i+3:4i].
- negative  out  1  result is negative.
- entry_mode  out  1  1 = operands shown (scan logic lights the dp between A and B); 0 = result shown.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the result is written.
- div_error  out  1  last divide had B=0.

Behaviour:
- Reset (async, reset_n=0): display_bcd=0, negative=0, entry_mode=1, busy=0, done=0, div_error=0, saved operands=0, lockout counter=0, FSM=IDLE.
- Operands: A = upper DIGITS digits, B = lower DIGITS digits of display_bcd.
- Press detection:
  - Register the OR of all button inputs.
  - A press is accepted only on a 0->1 edge of that OR, while lockout=0, FSM=IDLE and busy=0.
  - On acceptance, load lockout=LOCKOUT; it counts down to 0.
  - Edges during lockout or busy are dropped, not queued.
- Priority when several bits are high on the accepted cycle: recall > add > sub > mul > div > lowest-index digit_btn.
- Digit press (1 cycle):
  - Digit i becomes (d+1) mod 10, with no carry into neighbouring digits.
  - Whole display copied to the saved register; entry_mode=1; negative=0; div_error unchanged.
- Recall press (1 cycle): display_bcd = saved register; entry_mode=1; negative=0; div_error=0.
- Op press, FSM sequence IDLE->LOAD->EXEC->CONV->WRITE->IDLE:
  - LOAD, DIGITS cycles: A and B converted to binary by multiply-by-10 accumulate, MS digit first.
  - EXEC, exactly AW+4 cycles for every op; shorter ops idle out the remaining cycles.
    - add: A+B.
    - sub: |A-B|; negative=1 iff B>A; A=B gives 0 with negative=0.
    - mul: A*B by shift-add.
    - div: q = floor(A*10/B) by restoring division over the AW+4-bit numerator; result = q/10, +1 if q mod 10 >= 5. B=0 gives result 0 and div_error=1.
  - CONV, RW cycles: double-dabble into 2*DIGITS BCD digits.
  - WRITE, 1 cycle: display_bcd=result, entry_mode=0, done=1.
- busy is high from the cycle after acceptance through the WRITE cycle inclusive: 1+DIGITS+AW+4+RW+1 cycles, which is 29 for DIGITS=2.
- Range: every result is below 10^(2*DIGITS), so no overflow path exists. The saved register is not modified by ops.
- Chained ops: a new op uses the current display (the result) split as A/B, matching legacy behaviour.
- Reset mid-operation aborts immediately to reset values; no done pulse is issued.

Test Plan:
- Reset, press digit_btn[3] 3x, digit_btn[1] 2x -> display 3020, entry_mode=1. Press digit_btn[3] 7 more times -> digit 3 wraps to 0, no carry into other digits.
- Operands 45|07, add -> busy high for exactly 29 cycles, done pulse, display 0052, negative=0, entry_mode=0. Then recall -> 4507, entry_mode=1.
- Operands 12|30, sub -> display 0018, negative=1. Operands 30|30, sub -> 0000, negative=0.
- Operands 99|99, mul -> 9801. Operands 10|03, div -> 0003 (q=33). Operands 05|02, div -> 0003 (q=25 rounds up). Operands 07|00, div -> 0000, div_error=1.
- Second press edge 3 cycles after an accepted press, and an add pressed while busy -> both ignored, display unchanged. digit_btn[0] and op_btn[3] pressed together -> add wins.
- reset_n pulled low during CONV -> all outputs at reset values, no done pulse, next add works from a 0000 display.
